// File: rtl/datapath_core_pkg.sv
// Shared definitions for the single-bus datapath.
//   WIDTH     : data width of every register and the bus
//   bus_sel_e : bus source after priority encoding of the out-strobes
//   alu_op_e  : ALU operation after priority encoding of the op strobes
package datapath_core_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_PC,
    BUS_Z,
    BUS_MDR,
    BUS_R1,
    BUS_R2,
    BUS_R3,
    BUS_R4
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_INC,
    ALU_NEG
  } alu_op_e;

endpackage

// File: rtl/datapath_core_reg32.sv
// Load-enabled register with asynchronous active-low clear.
//   clock : rising-edge clock
//   clear : async active-low clear to 0
//   ld    : load d on the next rising edge, otherwise hold
//   d / q : data in / registered data out
module reg32
  import datapath_core_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb q_d = ld ? d : q_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/datapath_core.sv
// 32-bit single-bus CPU datapath: R1-R4, PC, IR, MAR, MDR, Y, Zlow, a
// priority bus mux and a small ALU (A = Y, B = bus).
//   clock, clear        : rising-edge clock, async active-low clear
//   *in strobes         : load the named register (MDR via its input mux,
//                         Zlow from the ALU, the rest from the bus)
//   *out strobes        : drive the named register onto the bus
//   MD_read             : MDR input mux, 1 = Mdatain, 0 = bus
//   IncPC, NEGATE       : ALU op select (default is Y + bus)
//   Mdatain             : memory read data
//   BusMuxOut           : current bus value
//   PC_q..R4_q          : register contents for observation / addressing
module datapath_core
  import datapath_core_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         R1in, R2in, R3in, R4in,
  input  logic         R1out, R2out, R3out, R4out,
  input  logic         PCin,
  input  logic         PCout,
  input  logic         IRin,
  input  logic         MARin,
  input  logic         MDRin,
  input  logic         MDRout,
  input  logic         MD_read,
  input  logic         Yin,
  input  logic         Zlowin,
  input  logic         Zlowout,
  input  logic         IncPC,
  input  logic         NEGATE,
  input  logic [W-1:0] Mdatain,
  output logic [W-1:0] BusMuxOut,
  output logic [W-1:0] PC_q,
  output logic [W-1:0] IR_q,
  output logic [W-1:0] MAR_q,
  output logic [W-1:0] Z_q,
  output logic [W-1:0] R1_q,
  output logic [W-1:0] R2_q,
  output logic [W-1:0] R3_q,
  output logic [W-1:0] R4_q
);

  logic [W-1:0] mdr_q, y_q;
  logic [W-1:0] mdr_d, alu_res;
  bus_sel_e     bus_sel;
  alu_op_e      alu_op;

  // Bus source priority; only out-strobes and register outputs feed the
  // bus, so no in-strobe can reach BusMuxOut combinationally.
  always_comb begin
    bus_sel = BUS_NONE;
    if      (PCout)   bus_sel = BUS_PC;
    else if (Zlowout) bus_sel = BUS_Z;
    else if (MDRout)  bus_sel = BUS_MDR;
    else if (R1out)   bus_sel = BUS_R1;
    else if (R2out)   bus_sel = BUS_R2;
    else if (R3out)   bus_sel = BUS_R3;
    else if (R4out)   bus_sel = BUS_R4;
  end

  always_comb begin
    BusMuxOut = '0;
    unique case (bus_sel)
      BUS_PC:  BusMuxOut = PC_q;
      BUS_Z:   BusMuxOut = Z_q;
      BUS_MDR: BusMuxOut = mdr_q;
      BUS_R1:  BusMuxOut = R1_q;
      BUS_R2:  BusMuxOut = R2_q;
      BUS_R3:  BusMuxOut = R3_q;
      BUS_R4:  BusMuxOut = R4_q;
      default: BusMuxOut = '0;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    if      (IncPC)  alu_op = ALU_INC;
    else if (NEGATE) alu_op = ALU_NEG;
  end

  // Wraps modulo 2^W; negating 0 gives 0 naturally.
  always_comb begin
    alu_res = y_q + BusMuxOut;
    unique case (alu_op)
      ALU_INC: alu_res = BusMuxOut + W'(1);
      ALU_NEG: alu_res = (~BusMuxOut) + W'(1);
      default: alu_res = y_q + BusMuxOut;
    endcase
  end

  assign mdr_d = MD_read ? Mdatain : BusMuxOut;

  reg32 #(.W(W)) u_r1  (.clock(clock), .clear(clear), .ld(R1in),   .d(BusMuxOut), .q(R1_q));
  reg32 #(.W(W)) u_r2  (.clock(clock), .clear(clear), .ld(R2in),   .d(BusMuxOut), .q(R2_q));
  reg32 #(.W(W)) u_r3  (.clock(clock), .clear(clear), .ld(R3in),   .d(BusMuxOut), .q(R3_q));
  reg32 #(.W(W)) u_r4  (.clock(clock), .clear(clear), .ld(R4in),   .d(BusMuxOut), .q(R4_q));
  reg32 #(.W(W)) u_pc  (.clock(clock), .clear(clear), .ld(PCin),   .d(BusMuxOut), .q(PC_q));
  reg32 #(.W(W)) u_ir  (.clock(clock), .clear(clear), .ld(IRin),   .d(BusMuxOut), .q(IR_q));
  reg32 #(.W(W)) u_mar (.clock(clock), .clear(clear), .ld(MARin),  .d(BusMuxOut), .q(MAR_q));
  reg32 #(.W(W)) u_mdr (.clock(clock), .clear(clear), .ld(MDRin),  .d(mdr_d),     .q(mdr_q));
  reg32 #(.W(W)) u_y   (.clock(clock), .clear(clear), .ld(Yin),    .d(BusMuxOut), .q(y_q));
  reg32 #(.W(W)) u_z   (.clock(clock), .clear(clear), .ld(Zlowin), .d(alu_res),   .q(Z_q));

endmodule

// File: tb/tb_datapath_core.sv
// Scoreboard bench for datapath_core: expected values are queued when a
// step is driven and popped/compared once the step's results are visible.
module tb_datapath_core;

  logic        clock = 1'b0;
  logic        clear;
  logic        R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out;
  logic        PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read, Yin;
  logic        Zlowin, Zlowout, IncPC, NEGATE;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, Z_q, R1_q, R2_q, R3_q, R4_q;

  datapath_core dut (
    .clock(clock), .clear(clear),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in),
    .R1out(R1out), .R2out(R2out), .R3out(R3out), .R4out(R4out),
    .PCin(PCin), .PCout(PCout), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MD_read(MD_read), .Yin(Yin),
    .Zlowin(Zlowin), .Zlowout(Zlowout), .IncPC(IncPC), .NEGATE(NEGATE),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
    .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .Z_q(Z_q),
    .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .R4_q(R4_q)
  );

  always #5 clock = ~clock;

  typedef enum int {O_BUS, O_PC, O_IR, O_MAR, O_Z, O_R1, O_R2, O_R3, O_R4} obs_e;
  typedef struct {
    string       tag;
    obs_e        src;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs(input obs_e s);
    case (s)
      O_PC:    return PC_q;
      O_IR:    return IR_q;
      O_MAR:   return MAR_q;
      O_Z:     return Z_q;
      O_R1:    return R1_q;
      O_R2:    return R2_q;
      O_R3:    return R3_q;
      O_R4:    return R4_q;
      default: return BusMuxOut;
    endcase
  endfunction

  task automatic push(input string tag, input obs_e src, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.src = src; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.src), e.val);
    end
  endtask

  task automatic push_all_zero(input string tag);
    push({tag, "_pc"},  O_PC,  '0); push({tag, "_ir"},  O_IR,  '0);
    push({tag, "_mar"}, O_MAR, '0); push({tag, "_z"},   O_Z,   '0);
    push({tag, "_r1"},  O_R1,  '0); push({tag, "_r2"},  O_R2,  '0);
    push({tag, "_r3"},  O_R3,  '0); push({tag, "_r4"},  O_R4,  '0);
  endtask

  task automatic idle();
    {R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out} = '0;
    {PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read, Yin} = '0;
    {Zlowin, Zlowout, IncPC, NEGATE} = '0;
  endtask

  task automatic rand_strobes();
    {R1in, R2in, R3in, R4in, R1out, R2out, R3out, R4out} = 8'($urandom);
    {PCin, PCout, IRin, MARin, MDRin, MDRout, MD_read, Yin} = 8'($urandom);
    {Zlowin, Zlowout, IncPC, NEGATE} = 4'($urandom);
    Mdatain = $urandom;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
    drain();
  endtask

  // Memory word -> MDR -> destination register (two steps).
  task automatic load_via_mdr(input logic [31:0] v, input int dst);
    idle(); Mdatain = v; MD_read = 1; MDRin = 1;
    step();
    idle(); MDRout = 1;
    case (dst)
      1: R1in = 1;
      2: R2in = 1;
      3: R3in = 1;
      4: R4in = 1;
      default: Yin = 1;
    endcase
    step();
  endtask

  initial begin
    idle(); Mdatain = '0; clear = 1'b0;
    @(negedge clock);
    // Random strobes while held in reset must not load anything.
    for (int i = 0; i < 4; i++) begin
      rand_strobes();
      @(posedge clock); #1;
    end
    push_all_zero("rst_hold");
    drain();
    idle(); clear = 1'b1;
    push_all_zero("rst_rel"); push("rst_bus", O_BUS, '0);
    step();

    load_via_mdr(32'h6, 2);
    push("ld_r2", O_R2, 32'h6); drain();
    load_via_mdr(32'h14, 3);
    load_via_mdr(32'h18, 1);
    push("ld_r3", O_R3, 32'h14); push("ld_r1", O_R1, 32'h18); drain();

    // Fetch
    idle(); PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
    push("f1_mar", O_MAR, 32'h0); push("f1_z", O_Z, 32'h1);
    step();
    idle(); Zlowout = 1; PCin = 1; MD_read = 1; MDRin = 1; Mdatain = 32'h2;
    push("f2_pc", O_PC, 32'h1);
    step();
    idle(); MDRout = 1; IRin = 1; #1;
    push("f3_bus_mdr", O_BUS, 32'h2); drain();
    push("f3_ir", O_IR, 32'h2);
    step();

    // Negate R3 into R1
    idle(); R2out = 1; Yin = 1;
    step();
    idle(); R3out = 1; NEGATE = 1; Zlowin = 1;
    push("neg_z", O_Z, 32'hFFFF_FFEC);
    step();
    idle(); Zlowout = 1; R1in = 1;
    push("neg_r1", O_R1, 32'hFFFF_FFEC);
    step();
    idle(); NEGATE = 1; Zlowin = 1;
    push("neg_zero", O_Z, 32'h0);
    step();

    // Add with wrap: Y = 0xFFFFFFFF, R4 = 2
    load_via_mdr(32'hFFFF_FFFF, 0);
    load_via_mdr(32'h2, 4);
    idle(); R4out = 1; Zlowin = 1;
    push("add_wrap", O_Z, 32'h1);
    step();
    // Y = 6 plus R2 = 6 without wrap
    idle(); R2out = 1; Yin = 1;
    step();
    idle(); R2out = 1; Zlowin = 1;
    push("add_plain", O_Z, 32'hC);
    step();

    // Zlow as both source and destination: old value on bus, new captured.
    idle(); Zlowout = 1; Zlowin = 1; NEGATE = 1; #1;
    push("self_bus", O_BUS, 32'hC); drain();
    push("self_z", O_Z, 32'hFFFF_FFF4);
    step();

    // Bus priority and idle bus
    idle(); PCout = 1; R2out = 1; #1;
    push("pri_pc_r2", O_BUS, 32'h1); drain();
    idle(); Zlowout = 1; MDRout = 1; R1out = 1; #1;
    push("pri_z_mdr", O_BUS, 32'hFFFF_FFF4); drain();
    idle(); MDRout = 1; R1out = 1; #1;
    push("pri_mdr_r1", O_BUS, 32'h2); drain();
    idle(); R3out = 1; R4out = 1; #1;
    push("pri_r3_r4", O_BUS, 32'h14); drain();
    idle(); #1;
    push("bus_idle", O_BUS, 32'h0); drain();

    // MDR loads from the bus when MD_read = 0
    idle(); R2out = 1; MDRin = 1; MD_read = 0; Mdatain = 32'hDEAD_BEEF;
    step();
    idle(); MDRout = 1; #1;
    push("mdr_bus", O_BUS, 32'h6); drain();

    // Reset mid-sequence with loads asserted clears immediately.
    idle(); R1in = 1; R4out = 1; MDRin = 1; MD_read = 1; Mdatain = 32'h55;
    @(negedge clock);
    clear = 1'b0; #1;
    push_all_zero("rst_mid"); push("rst_mid_bus", O_BUS, '0); drain();
    @(posedge clock); #1;
    push_all_zero("rst_mid_edge"); drain();
    idle(); MDRout = 1; clear = 1'b1;
    push("rst_mid_mdr", O_BUS, '0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded budget", $time);
    $fatal(1);
  end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- 32-bit single-bus CPU datapath.
- Contains R1–R4, PC, IR, MAR, MDR, Y and Zlow registers, a bus multiplexer and a small ALU.
- The control unit, or a bench FSM, drives the register in/out strobes one step per clock.
- Memory data enters through the MDR input mux.
- The block sits between the control unit and the memory interface of the CPU top level.

Parameters:
- WIDTH, 32, data width of all registers and the bus.

Ports:
- clock  in  1  single system clock; all registers load on the rising edge.
- clear  in  1  asynchronous, active-low reset; clears every register to 0.
- R1in, R2in, R3in, R4in  in  1 each  load enable for R1..R4 from the bus.
- R1out, R2out, R3out, R4out  in  1 each  drive R1..R4 onto the bus.
- PCin  in  1  load PC from the bus.
- PCout  in  1  drive PC onto the bus.
- IRin  in  1  load IR from the bus.
- MARin  in  1  load MAR from the bus.
- MDRin  in  1  load MDR from the MDR input mux.
- MDRout  in  1  drive MDR onto the bus.
- MD_read  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
- Yin  in  1  load Y from the bus.
- Zlowin  in  1  load Zlow from the ALU result.
- Zlowout  in  1  drive Zlow onto the bus.
- IncPC  in  1  ALU op: result = bus + 1.
- NEGATE  in  1  ALU op: result = 0 − bus (two's complement).
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value.
- PC_q, IR_q, MAR_q, Z_q, R1_q..R4_q  out  32 each  register contents, for observation and for the memory address.

Behaviour:
- Reset:
  - clear = 0 asynchronously forces R1–R4, PC, IR, MAR, MDR, Y and Zlow to 0x00000000.
  - All _q outputs therefore read 0 immediately.
  - Reset overrides any load asserted in the same cycle, including reset asserted mid-sequence.
  - Registers hold 0 until the first rising edge after clear returns to 1.
- Registers: each loads its input on a rising clock edge when its in-strobe is 1; otherwise it holds.
- Bus:
  - Purely combinational.
  - Selected source priority when several out-strobes are high: PCout > Zlowout > MDRout > R1out > R2out > R3out > R4out.
  - No out-strobe high → bus = 0.
- MDR input mux: MD_read = 1 selects Mdatain, 0 selects BusMuxOut. MDR loads only when MDRin = 1.
- ALU:
  - Purely combinational; operand A = Y, operand B = bus.
  - Priority: IncPC → B + 1; else NEGATE → (~B) + 1; else → A + B.
  - Results wrap modulo 2^32 with no flags; −0 = 0.
  - Zlow captures the result only on an edge with Zlowin = 1.
- Latency:
  - A register-to-register transfer completes in one clock: out-strobe and in-strobe asserted together, captured on the next rising edge.
  - An ALU operation takes two steps: load Z, then a separate step with Zlowout plus a destination in-strobe.
- Simultaneous source and destination on the same register (e.g. Zlowout and Zlowin): the old value drives the bus, and the new value is captured at the edge.
- Strobes change between edges; no combinational path from any in-strobe to BusMuxOut.

Decomposition:
- Shared package:
  - WIDTH constant.
  - Bus-source select encoding, an enum used internally after priority encoding.
  - ALU op enum: ADD, INC, NEG.
- One natural sub-module: reg32, a WIDTH-bit register with load enable and async active-low clear, instantiated for every register.
- Bus mux and ALU stay inline.

Test Plan:
- Reset: hold clear = 0 with random strobes, then release → all _q = 0. Assert clear = 0 mid-sequence → all _q = 0 immediately.
- Register load via MDR:
  - Mdatain = 0x6, MD_read = 1, MDRin = 1, edge; then MDRout = 1, R2in = 1, edge → R2_q = 0x00000006.
  - Same sequence with 0x14 into R3 and 0x18 into R1 → R3_q = 0x14, R1_q = 0x18.
- Fetch:
  - PCout, MARin, IncPC, Zlowin with PC = 0 → MAR_q = 0, Z_q = 1.
  - Then Zlowout, PCin, MD_read, MDRin with Mdatain = 0x2 → PC_q = 1, MDR = 0x2.
  - Then MDRout, IRin → IR_q = 0x00000002.
- Negate: R2out, Yin (Y = 6); then R3out, NEGATE, Zlowin → Z_q = 0xFFFFFFEC; then Zlowout, R1in → R1_q = 0xFFFFFFEC. Also negate of 0 → 0.
- Add and wrap: Y = 0xFFFFFFFF, R4 = 2 on the bus, Zlowin, no op strobe → Z_q = 0x00000001.
- Bus priority and idle:
  - PCout and R2out together → bus = PC.
  - No out-strobes → bus = 0.
  - MDRin with MD_read = 0 → MDR loads the bus value.
